toggle_sequencer: RTL and testbench



---
 rtl/toggle_sequencer.sv | 126 ++++++++++++
 tb/tb_toggle_sequencer.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/toggle_sequencer.sv
// toggle_sequencer: valid/ready command sequencer issuing 1-cycle T-enable pulses to a T flip-flop bank.
// Optional abort input is compiled in when TSEQ_ABORT_EN is defined.
module toggle_sequencer #(
    parameter int WIDTH = 4,
    parameter int CNT_W = 8,
    parameter int GAP_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [WIDTH-1:0] cmd_mask,
    input  logic [CNT_W-1:0] cmd_count,
    input  logic [GAP_W-1:0] cmd_gap,
`ifdef TSEQ_ABORT_EN
    input  logic             abort,
`endif
    output logic [WIDTH-1:0] t_out,
    output logic [WIDTH-1:0] q,
    output logic             busy,
    output logic             done
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] PULSE = 2'd1;
    localparam logic [1:0] GAP   = 2'd2;
    localparam logic [1:0] DONE  = 2'd3;

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [GAP_W-1:0] GAP_ONE = {{(GAP_W-1){1'b0}}, 1'b1};

    logic [1:0]       state_q,   state_d;
    logic [WIDTH-1:0] mask_q,    mask_d;
    logic [CNT_W-1:0] cnt_q,     cnt_d;
    logic [GAP_W-1:0] gap_q,     gap_d;
    logic [GAP_W-1:0] gap_cnt_q, gap_cnt_d;
    logic [WIDTH-1:0] t_out_q,   t_out_d;
    logic [WIDTH-1:0] q_q,       q_d;
    logic             done_q,    done_d;
    logic             abort_hit;

`ifdef TSEQ_ABORT_EN
    assign abort_hit = abort;
`else
    assign abort_hit = 1'b0;
`endif

    always_comb begin
        state_d   = state_q;
        mask_d    = mask_q;
        cnt_d     = cnt_q;
        gap_d     = gap_q;
        gap_cnt_d = gap_cnt_q;
        case (state_q)
            IDLE: begin
                if (cmd_valid) begin
                    mask_d  = cmd_mask;
                    cnt_d   = cmd_count;
                    gap_d   = cmd_gap;
                    state_d = (cmd_count == '0) ? DONE : PULSE;
                end
            end
            PULSE: begin
                cnt_d = cnt_q - CNT_ONE;
                if (abort_hit || (cnt_q == CNT_ONE)) begin
                    state_d = DONE;
                end else if (gap_q == '0) begin
                    state_d = PULSE;
                end else begin
                    state_d   = GAP;
                    gap_cnt_d = gap_q;
                end
            end
            GAP: begin
                if (abort_hit) begin
                    state_d = DONE;
                end else if (gap_cnt_q == GAP_ONE) begin
                    state_d   = PULSE;
                    gap_cnt_d = '0;
                end else begin
                    gap_cnt_d = gap_cnt_q - GAP_ONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Outputs are registered, so they are decoded from the state being entered.
        t_out_d = (state_d == PULSE) ? mask_d : '0;
        done_d  = (state_d == DONE);
        q_d     = q_q ^ t_out_q;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= IDLE;
            mask_q    <= '0;
            cnt_q     <= '0;
            gap_q     <= '0;
            gap_cnt_q <= '0;
            t_out_q   <= '0;
            q_q       <= '0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            mask_q    <= mask_d;
            cnt_q     <= cnt_d;
            gap_q     <= gap_d;
            gap_cnt_q <= gap_cnt_d;
            t_out_q   <= t_out_d;
            q_q       <= q_d;
            done_q    <= done_d;
        end
    end

    assign cmd_ready = (state_q == IDLE);
    assign busy      = (state_q != IDLE);
    assign t_out     = t_out_q;
    assign q         = q_q;
    assign done      = done_q;

endmodule

// File: tb/tb_toggle_sequencer.sv
// tb_toggle_sequencer: table vectors, hand sequences and random commands checked against a cycle-timeline model.
// Abort coverage is included when TSEQ_ABORT_EN is defined.
module tb_toggle_sequencer;

    typedef struct packed {
        logic [3:0] mask;
        logic [7:0] count;
        logic [3:0] gap;
        int         abort_at;
        int         exp_cycles;
        int         exp_pulses;
        logic [3:0] exp_q_delta;
    } vec_t;

    logic       clk;
    logic       rst;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [3:0] cmd_mask;
    logic [7:0] cmd_count;
    logic [3:0] cmd_gap;
`ifdef TSEQ_ABORT_EN
    logic       abort;
`endif
    logic [3:0] t_out;
    logic [3:0] q;
    logic       busy;
    logic       done;

    int         vectors;
    int         miscompares;
    logic [3:0] q_model;

    toggle_sequencer #(.WIDTH(4), .CNT_W(8), .GAP_W(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_mask  (cmd_mask),
        .cmd_count (cmd_count),
        .cmd_gap   (cmd_gap),
`ifdef TSEQ_ABORT_EN
        .abort     (abort),
`endif
        .t_out     (t_out),
        .q         (q),
        .busy      (busy),
        .done      (done)
    );

    // Clock starts high so negedges fall on 5, 15, 25 ns and posedges on 10, 20, 30 ns.
    initial clk = 1'b1;
    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        vectors++;
        if (actual !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, actual, expected, $time);
        end
    endtask

    // Called just after a negedge with the DUT idle; returns just after the negedge of the idle cycle that follows.
    task automatic applyStimulus(input logic [3:0] m, input logic [7:0] c, input logic [3:0] g,
                                 input int abort_at, output int pulses_seen, output int cycles_seen);
        int         ci;
        int         gi;
        int         total;
        logic [3:0] exp_t;
        ci = int'(c);
        gi = int'(g);
        total = (ci == 0) ? 1 : ci * (gi + 1) - gi + 1;
        if (abort_at > 0 && abort_at < total) total = abort_at + 1;
        pulses_seen = 0;
        cycles_seen = 0;
        cmd_valid = 1'b1;
        cmd_mask  = m;
        cmd_count = c;
        cmd_gap   = g;
        for (int k = 1; k <= total; k++) begin
            @(negedge clk);
            cmd_valid = 1'($urandom_range(0, 1));
            cmd_mask  = 4'($urandom);
            cmd_count = 8'($urandom);
            cmd_gap   = 4'($urandom);
`ifdef TSEQ_ABORT_EN
            abort = (k == abort_at);
`endif
            exp_t = (k < total && ((k - 1) % (gi + 1)) == 0) ? m : 4'b0000;
            checkOutput("t_out", t_out, exp_t);
            checkOutput("q", q, q_model);
            checkOutput("done", done, (k == total));
            checkOutput("busy", busy, 1);
            checkOutput("cmd_ready", cmd_ready, 0);
            if (busy) cycles_seen++;
            if (t_out != 4'b0000) pulses_seen++;
            q_model = q_model ^ exp_t;
        end
        @(negedge clk);
        cmd_valid = 1'b0;
`ifdef TSEQ_ABORT_EN
        abort = 1'($urandom_range(0, 1));
`endif
        checkOutput("idle_busy", busy, 0);
        checkOutput("idle_ready", cmd_ready, 1);
        checkOutput("idle_done", done, 0);
        checkOutput("idle_t_out", t_out, 0);
        checkOutput("idle_q", q, q_model);
    endtask

    localparam int NV = 10;
    vec_t tbl [NV];

    initial begin
        int         pulses;
        int         cycles;
        logic [3:0] q_start;
        int         ab;

        tbl[0] = '{4'b0101, 8'd3,   4'd0,  0, 4,   3,   4'b0101};
        tbl[1] = '{4'b1000, 8'd2,   4'd2,  0, 5,   2,   4'b0000};
        tbl[2] = '{4'b1111, 8'd0,   4'd0,  0, 1,   0,   4'b0000};
        tbl[3] = '{4'b0000, 8'd2,   4'd1,  0, 4,   0,   4'b0000};
        tbl[4] = '{4'b0011, 8'd1,   4'd5,  0, 2,   1,   4'b0011};
        tbl[5] = '{4'b1010, 8'd4,   4'd15, 0, 50,  4,   4'b0000};
        tbl[6] = '{4'b0110, 8'd255, 4'd0,  0, 256, 255, 4'b0110};
        tbl[7] = '{4'b1001, 8'd3,   4'd15, 0, 34,  3,   4'b1001};
        tbl[8] = '{4'b0001, 8'd1,   4'd0,  0, 2,   1,   4'b0001};
        tbl[9] = '{4'b0100, 8'd5,   4'd3,  0, 18,  5,   4'b0100};

        vectors     = 0;
        miscompares = 0;
        q_model     = 4'b0000;
        rst         = 1'b0;
        cmd_valid   = 1'b0;
        cmd_mask    = 4'b0000;
        cmd_count   = 8'd0;
        cmd_gap     = 4'd0;
`ifdef TSEQ_ABORT_EN
        abort       = 1'b0;
`endif

        #12;
        checkOutput("rst_q", q, 0);
        checkOutput("rst_t_out", t_out, 0);
        checkOutput("rst_busy", busy, 0);
        checkOutput("rst_done", done, 0);
        checkOutput("rst_ready", cmd_ready, 1);
        #3;
        rst = 1'b1;

        for (int i = 0; i < NV; i++) begin
            q_start = q_model;
            applyStimulus(tbl[i].mask, tbl[i].count, tbl[i].gap, tbl[i].abort_at, pulses, cycles);
            checkOutput($sformatf("tbl%0d_cycles", i), cycles, tbl[i].exp_cycles);
            checkOutput($sformatf("tbl%0d_pulses", i), pulses, tbl[i].exp_pulses);
            checkOutput($sformatf("tbl%0d_q", i), q, q_start ^ tbl[i].exp_q_delta);
        end

`ifdef TSEQ_ABORT_EN
        // Abort in the first gap cycle: one pulse, then done.
        q_start = q_model;
        applyStimulus(4'b0010, 8'd5, 4'd3, 2, pulses, cycles);
        checkOutput("abort_cycles", cycles, 3);
        checkOutput("abort_pulses", pulses, 1);
        checkOutput("abort_q", q, q_start ^ 4'b0010);
`endif

        // Reset asserted while in the gap of a count=4 command.
        cmd_valid = 1'b1;
        cmd_mask  = 4'b0110;
        cmd_count = 8'd4;
        cmd_gap   = 4'd3;
`ifdef TSEQ_ABORT_EN
        abort     = 1'b0;
`endif
        @(negedge clk);
        cmd_valid = 1'b0;
        checkOutput("mid_pulse", t_out, 4'b0110);
        @(negedge clk);
        checkOutput("mid_gap_q", q, q_model ^ 4'b0110);
        checkOutput("mid_gap_t_out", t_out, 0);
        #2;
        rst = 1'b0;
        #1;
        q_model = 4'b0000;
        checkOutput("midrst_q", q, 0);
        checkOutput("midrst_busy", busy, 0);
        checkOutput("midrst_t_out", t_out, 0);
        checkOutput("midrst_ready", cmd_ready, 1);
        @(negedge clk);
        checkOutput("midrst_done", done, 0);
        rst = 1'b1;
        applyStimulus(4'b1100, 8'd2, 4'd1, 0, pulses, cycles);
        checkOutput("post_rst_cycles", cycles, 4);
        checkOutput("post_rst_q", q, 4'b0000);

        for (int n = 0; n < 30; n++) begin
`ifdef TSEQ_ABORT_EN
            ab = $urandom_range(0, 8);
`else
            ab = 0;
`endif
            applyStimulus(4'($urandom), 8'($urandom_range(0, 10)), 4'($urandom_range(0, 15)), ab, pulses, cycles);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
